// File: rtl/hex_digit_counter.sv
// Hex digit counter stepped by a clock-divided prescaler, with up/down
// direction, synchronous load and one-cycle tick/carry pulses.
module hex_digit_counter #(
   parameter int unsigned CLK_HZ  = 50000000,
   parameter int unsigned TICK_HZ = 1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       enable,
   input  logic       up,
   input  logic       load,
   input  logic [3:0] load_val,
   output logic [3:0] num,
   output logic       tick,
   output logic       carry
);

   localparam int unsigned DIV  = (CLK_HZ / TICK_HZ < 1) ? 1 : CLK_HZ / TICK_HZ;
   localparam int unsigned PW   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PW-1:0] LAST = PW'(DIV - 1);

   logic [PW-1:0] presc_q, presc_d;
   logic [3:0]    num_q, num_d;
   logic          tick_q, tick_d;
   logic          carry_q, carry_d;

   // Next state: load beats step, step beats hold; pulses default low.
   always_comb begin
      presc_d = presc_q;
      num_d   = num_q;
      tick_d  = 1'b0;
      carry_d = 1'b0;
      if (load) begin
         num_d   = load_val;
         presc_d = '0;
      end else if (enable) begin
         if (presc_q == LAST) begin
            presc_d = '0;
            tick_d  = 1'b1;
            if (up) begin
               num_d   = num_q + 4'd1;
               carry_d = (num_q == 4'hF);
            end else begin
               num_d   = num_q - 4'd1;
               carry_d = (num_q == 4'h0);
            end
         end else begin
            presc_d = presc_q + PW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q <= '0;
         num_q   <= 4'h0;
         tick_q  <= 1'b0;
         carry_q <= 1'b0;
      end else begin
         presc_q <= presc_d;
         num_q   <= num_d;
         tick_q  <= tick_d;
         carry_q <= carry_d;
      end
   end

   assign num   = num_q;
   assign tick  = tick_q;
   assign carry = carry_q;

endmodule

// File: tb/tb_hex_digit_counter.sv
// Directed self-checking bench for hex_digit_counter with DIV=4.
module tb_hex_digit_counter;

   logic       clk = 1'b0;
   logic       reset, enable, up, load;
   logic [3:0] load_val;
   logic [3:0] num;
   logic       tick, carry;
   int         passed = 0;
   int         total  = 0;

   hex_digit_counter #(.CLK_HZ(4), .TICK_HZ(1)) dut (
      .clk(clk), .reset(reset), .enable(enable), .up(up), .load(load),
      .load_val(load_val), .num(num), .tick(tick), .carry(carry)
   );

   always #5 clk = ~clk;

   // Advance one edge and settle just after it.
   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; enable = 1'b1; up = 1'b1; load = 1'b1; load_val = 4'h5;
      cyc();
      total++;
      if ({num, tick, carry} !== {4'h0, 1'b0, 1'b0})
         $display("FAIL reset got num=%h tick=%b carry=%b exp num=0 tick=0 carry=0", num, tick, carry);
      else passed++;
      reset = 1'b0; load = 1'b0; enable = 1'b0;
   endtask

   task automatic test_count_up();
      logic [3:0] e_num;
      logic       e_tick;
      enable = 1'b1; up = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         cyc();
         e_num  = 4'(i / 4);
         e_tick = (i % 4 == 0);
         total++;
         if ({num, tick, carry} !== {e_num, e_tick, 1'b0})
            $display("FAIL count_up cyc=%0d got num=%h tick=%b carry=%b exp num=%h tick=%b carry=0",
                     i, num, tick, carry, e_num, e_tick);
         else passed++;
      end
      enable = 1'b0;
   endtask

   task automatic test_wrap_up();
      logic [3:0] e_num;
      logic       e_pulse;
      load = 1'b1; load_val = 4'hF; enable = 1'b0;
      cyc();
      total++;
      if ({num, tick, carry} !== {4'hF, 1'b0, 1'b0})
         $display("FAIL load_f got num=%h tick=%b carry=%b exp num=f tick=0 carry=0", num, tick, carry);
      else passed++;
      load = 1'b0; enable = 1'b1; up = 1'b1;
      for (int i = 1; i <= 5; i++) begin
         cyc();
         e_num   = (i >= 4) ? 4'h0 : 4'hF;
         e_pulse = (i == 4);
         total++;
         if ({num, tick, carry} !== {e_num, e_pulse, e_pulse})
            $display("FAIL wrap_up cyc=%0d got num=%h tick=%b carry=%b exp num=%h tick=%b carry=%b",
                     i, num, tick, carry, e_num, e_pulse, e_pulse);
         else passed++;
      end
      enable = 1'b0;
   endtask

   task automatic test_wrap_down();
      logic [3:0] e_num;
      logic       e_tick, e_carry;
      load = 1'b1; load_val = 4'h0;
      cyc();
      load = 1'b0; enable = 1'b1; up = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         cyc();
         e_num   = (i < 4) ? 4'h0 : ((i < 8) ? 4'hF : 4'hE);
         e_tick  = (i == 4) || (i == 8);
         e_carry = (i == 4);
         total++;
         if ({num, tick, carry} !== {e_num, e_tick, e_carry})
            $display("FAIL wrap_down cyc=%0d got num=%h tick=%b carry=%b exp num=%h tick=%b carry=%b",
                     i, num, tick, carry, e_num, e_tick, e_carry);
         else passed++;
      end
      enable = 1'b0;
   endtask

   task automatic test_enable_hold();
      load = 1'b1; load_val = 4'h0;
      cyc();
      load = 1'b0; up = 1'b1; enable = 1'b1;
      cyc(); cyc();
      enable = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         cyc();
         total++;
         if ({num, tick, carry} !== {4'h0, 1'b0, 1'b0})
            $display("FAIL hold cyc=%0d got num=%h tick=%b carry=%b exp num=0 tick=0 carry=0",
                     i, num, tick, carry);
         else passed++;
      end
      enable = 1'b1;
      cyc();
      total++;
      if ({num, tick, carry} !== {4'h0, 1'b0, 1'b0})
         $display("FAIL resume_early got num=%h tick=%b carry=%b exp num=0 tick=0 carry=0", num, tick, carry);
      else passed++;
      cyc();
      total++;
      if ({num, tick, carry} !== {4'h1, 1'b1, 1'b0})
         $display("FAIL resume_step got num=%h tick=%b carry=%b exp num=1 tick=1 carry=0", num, tick, carry);
      else passed++;
      enable = 1'b0;
   endtask

   task automatic test_load_priority();
      logic [3:0] e_num;
      logic       e_tick;
      load = 1'b1; load_val = 4'h0;
      cyc();
      load = 1'b0; up = 1'b1; enable = 1'b1;
      cyc(); cyc(); cyc();
      // Prescaler now at its last count: load must win over the step.
      load = 1'b1; load_val = 4'h9;
      cyc();
      total++;
      if ({num, tick, carry} !== {4'h9, 1'b0, 1'b0})
         $display("FAIL load_prio got num=%h tick=%b carry=%b exp num=9 tick=0 carry=0", num, tick, carry);
      else passed++;
      load = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         cyc();
         e_num  = (i == 4) ? 4'hA : 4'h9;
         e_tick = (i == 4);
         total++;
         if ({num, tick, carry} !== {e_num, e_tick, 1'b0})
            $display("FAIL after_load cyc=%0d got num=%h tick=%b carry=%b exp num=%h tick=%b carry=0",
                     i, num, tick, carry, e_num, e_tick);
         else passed++;
      end
      enable = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [3:0] e_num;
      logic       e_tick;
      load = 1'b1; load_val = 4'h7;
      cyc();
      load = 1'b0; up = 1'b1; enable = 1'b1;
      cyc(); cyc();
      reset = 1'b1;
      cyc();
      total++;
      if ({num, tick, carry} !== {4'h0, 1'b0, 1'b0})
         $display("FAIL reset_mid got num=%h tick=%b carry=%b exp num=0 tick=0 carry=0", num, tick, carry);
      else passed++;
      reset = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         cyc();
         e_num  = (i == 4) ? 4'h1 : 4'h0;
         e_tick = (i == 4);
         total++;
         if ({num, tick, carry} !== {e_num, e_tick, 1'b0})
            $display("FAIL after_reset cyc=%0d got num=%h tick=%b carry=%b exp num=%h tick=%b carry=0",
                     i, num, tick, carry, e_num, e_tick);
         else passed++;
      end
      enable = 1'b0;
   endtask

   task automatic test_dir_change();
      load = 1'b1; load_val = 4'h5;
      cyc();
      load = 1'b0; enable = 1'b1; up = 1'b1;
      cyc(); cyc();
      up = 1'b0;
      cyc(); cyc();
      total++;
      if ({num, tick, carry} !== {4'h4, 1'b1, 1'b0})
         $display("FAIL dir_change got num=%h tick=%b carry=%b exp num=4 tick=1 carry=0", num, tick, carry);
      else passed++;
      enable = 1'b0;
   endtask

   initial begin
      reset = 1'b0; enable = 1'b0; up = 1'b1; load = 1'b0; load_val = 4'h0;
      test_reset();
      test_count_up();
      test_wrap_up();
      test_wrap_down();
      test_enable_hold();
      test_load_priority();
      test_reset_mid();
      test_dir_change();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
